uart_dump_ctrl: RTL and testbench

- Transmit-direction counterpart of the UART program loader.
- After the MIPS halts, it walks processor state and feeds it word by word to the 32-bit UART transmit interface (word -> 4 bytes -> serial).
- Dump order: header word, PC, register file r0..r31, data memory words 0..MEM_WORDS-1.
- Sits between the halted pipeline (register-file and data-memory debug read ports) and the UART word transmit interface.

---
 rtl/uart_dbg_pkg.sv | 27 ++
 rtl/uart_dump_ctrl.sv | 148 ++++++++++++++
 tb/tb_uart_dump_ctrl.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/uart_dbg_pkg.sv
// Shared encodings and constants for the UART debug dump path.
package uart_dbg_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StHdr,
        StRd,
        StCap,
        StSend,
        StWait,
        StNext,
        StFin
    } state_e;

    typedef enum logic [1:0] {
        SecHdr,
        SecPc,
        SecReg,
        SecMem
    } section_e;

    localparam logic [15:0] HdrTagDefault = 16'hD0D0;
    localparam int unsigned RegCount      = 32;
    // Header + PC + 32 registers.
    localparam int unsigned FixedWords    = 34;

endpackage

// File: rtl/uart_dump_ctrl.sv
// Post-halt state dump: streams header, PC, r0..r31 and data memory words
// to the UART word transmitter, one word per tx_start/tx_done handshake.
module uart_dump_ctrl
    import uart_dbg_pkg::*;
#(
    parameter int unsigned MemWords = 32,
    parameter logic [31:0] MemBase  = 32'h0000_0000,
    parameter logic [15:0] HdrTag   = HdrTagDefault
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        dump_start_i,
    input  logic [31:0] pc_value_i,
    output logic [4:0]  reg_addr_o,
    input  logic [31:0] reg_rdata_i,
    output logic [31:0] mem_addr_o,
    output logic        mem_rd_o,
    input  logic [31:0] mem_rdata_i,
    output logic [31:0] tx_word_o,
    output logic        tx_start_o,
    input  logic        tx_done_i,
    output logic        busy_o,
    output logic        dump_done_o
);

    localparam int unsigned TotalWords = FixedWords + MemWords;
    localparam logic [31:0] HeaderWord = {HdrTag, 16'(TotalWords)};

    state_e      state_q, state_d;
    section_e    sec_q, sec_d;
    logic [9:0]  idx_q, idx_d;
    logic [4:0]  reg_addr_q, reg_addr_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic        mem_rd_q, mem_rd_d;
    logic [31:0] tx_word_q, tx_word_d;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= StIdle;
            sec_q      <= SecHdr;
            idx_q      <= '0;
            reg_addr_q <= '0;
            mem_addr_q <= '0;
            mem_rd_q   <= 1'b0;
            tx_word_q  <= '0;
        end else begin
            state_q    <= state_d;
            sec_q      <= sec_d;
            idx_q      <= idx_d;
            reg_addr_q <= reg_addr_d;
            mem_addr_q <= mem_addr_d;
            mem_rd_q   <= mem_rd_d;
            tx_word_q  <= tx_word_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        sec_d      = sec_q;
        idx_d      = idx_q;
        reg_addr_d = reg_addr_q;
        mem_addr_d = mem_addr_q;
        mem_rd_d   = mem_rd_q;
        tx_word_d  = tx_word_q;

        unique case (state_q)
            StIdle: begin
                if (dump_start_i) begin
                    sec_d   = SecHdr;
                    idx_d   = '0;
                    state_d = StHdr;
                end
            end
            StHdr: begin
                tx_word_d = HeaderWord;
                state_d   = StSend;
            end
            StRd: begin
                mem_rd_d = 1'b0;
                state_d  = StCap;
            end
            StCap: begin
                unique case (sec_q)
                    SecPc:   tx_word_d = pc_value_i;
                    SecReg:  tx_word_d = reg_rdata_i;
                    SecMem:  tx_word_d = mem_rdata_i;
                    SecHdr:  tx_word_d = HeaderWord;
                endcase
                mem_rd_d = 1'b0;
                state_d  = StSend;
            end
            StSend: state_d = StWait;
            StWait: begin
                if (tx_done_i) begin
                    state_d = StNext;
                end
            end
            StNext: begin
                state_d = StRd;
                unique case (sec_q)
                    SecHdr: sec_d = SecPc;
                    SecPc: begin
                        sec_d = SecReg;
                        idx_d = '0;
                    end
                    SecReg: begin
                        if (idx_q != 10'(RegCount - 1)) begin
                            idx_d = idx_q + 10'd1;
                        end else if (MemWords == 0) begin
                            state_d = StFin;
                        end else begin
                            sec_d = SecMem;
                            idx_d = '0;
                        end
                    end
                    SecMem: begin
                        if (32'(idx_q) + 32'd1 < MemWords) begin
                            idx_d = idx_q + 10'd1;
                        end else begin
                            state_d = StFin;
                        end
                    end
                endcase
                // Address is presented during RD so the synchronous read data is ready in CAP.
                if (state_d == StRd) begin
                    if (sec_d == SecReg) begin
                        reg_addr_d = idx_d[4:0];
                    end
                    if (sec_d == SecMem) begin
                        mem_addr_d = MemBase + {20'b0, idx_d, 2'b00};
                        mem_rd_d   = 1'b1;
                    end
                end
            end
            StFin: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    assign reg_addr_o  = reg_addr_q;
    assign mem_addr_o  = mem_addr_q;
    assign mem_rd_o    = mem_rd_q;
    assign tx_word_o   = tx_word_q;
    assign tx_start_o  = (state_q == StSend);
    assign busy_o      = (state_q != StIdle) && (state_q != StFin);
    assign dump_done_o = (state_q == StFin);

endmodule

// File: tb/tb_uart_dump_ctrl.sv
// Directed bench for uart_dump_ctrl: three parameterisations, scoreboarded words and addresses.
module tb_uart_dump_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [2:0]  dump_start = '0;
    logic [31:0] pc_value = 32'h0000_0040;
    logic        tx_done = 1'b0;

    logic [4:0]  reg_addr  [3];
    logic [31:0] mem_addr  [3];
    logic [31:0] tx_word   [3];
    logic [2:0]  mem_rd, tx_start, busy, dump_done;

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < 3; g++) begin : gen_dut
        localparam int unsigned MW = (g == 0) ? 4 : (g == 1) ? 0 : 3;
        localparam logic [31:0] MB = (g == 2) ? 32'hFFFF_FFF8 : 32'h0;
        logic [31:0] reg_rdata = '0;
        logic [31:0] mem_rdata = '0;

        // Synchronous-read models: data follows the address by one cycle.
        always @(posedge clk) begin
            reg_rdata <= 32'(reg_addr[g]) * 32'h11;
            mem_rdata <= 32'hA0 + ((mem_addr[g] - MB) >> 2);
        end

        uart_dump_ctrl #(
            .MemWords (MW),
            .MemBase  (MB)
        ) u_dut (
            .clk_i        (clk),
            .rst_ni       (rst_n),
            .dump_start_i (dump_start[g]),
            .pc_value_i   (pc_value),
            .reg_addr_o   (reg_addr[g]),
            .reg_rdata_i  (reg_rdata),
            .mem_addr_o   (mem_addr[g]),
            .mem_rd_o     (mem_rd[g]),
            .mem_rdata_i  (mem_rdata),
            .tx_word_o    (tx_word[g]),
            .tx_start_o   (tx_start[g]),
            .tx_done_i    (tx_done),
            .busy_o       (busy[g]),
            .dump_done_o  (dump_done[g])
        );
    end

    int total = 0;
    int bad = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    logic [31:0] exp_q[$];
    logic [31:0] addr_q[$];
    int sel = 0;
    int words = 0;
    int dones = 0;
    int exp_words = 0;
    int start_cyc = 0;
    int last_done = -100;
    int cnt = 0;
    bit first_pend = 1'b0;
    bit spur_mode = 1'b0;

    // Transmitter model plus output scoreboard; tx_done follows each tx_start by 10 cycles.
    always @(negedge clk) begin
        tx_done = 1'b0;
        if (!rst_n) begin
            cnt = 0;
        end else if (cnt > 0) begin
            cnt--;
            if (cnt == 0) begin
                tx_done   = 1'b1;
                last_done = cyc;
            end
        end
        if (spur_mode && cyc == last_done + 2) tx_done = 1'b1;
        if (tx_start[sel]) begin
            words++;
            chk("busy_at_start", 32'(busy[sel]), 32'd1);
            if (exp_q.size() == 0) chk("unexpected_word", 32'(exp_q.size()), 32'd1);
            else chk("word", tx_word[sel], exp_q.pop_front());
            if (first_pend) begin
                chk("hdr_latency", 32'(cyc - start_cyc), 32'd2);
                first_pend = 1'b0;
            end else begin
                chk("done_to_start_gap", 32'(cyc - last_done), 32'd4);
            end
            if (spur_mode) tx_done = 1'b1;
            cnt = 10;
        end
        if (mem_rd[sel]) begin
            if (addr_q.size() == 0) chk("unexpected_mem_rd", 32'(addr_q.size()), 32'd1);
            else chk("mem_addr", mem_addr[sel], addr_q.pop_front());
        end
        if (dump_done[sel]) begin
            dones++;
            chk("busy_at_done", 32'(busy[sel]), 32'd0);
            chk("words_at_done", 32'(words), 32'(exp_words));
            chk("addr_queue_empty", 32'(addr_q.size()), 32'd0);
        end
    end

    task automatic setup(input int s, input int mw, input logic [31:0] base);
        sel = s;
        exp_q.delete();
        addr_q.delete();
        exp_q.push_back({16'hD0D0, 16'(34 + mw)});
        exp_q.push_back(32'h0000_0040);
        for (int i = 0; i < 32; i++) exp_q.push_back(32'(i) * 32'h11);
        for (int j = 0; j < mw; j++) begin
            exp_q.push_back(32'hA0 + 32'(j));
            addr_q.push_back(base + 32'(4 * j));
        end
        words      = 0;
        dones      = 0;
        exp_words  = 34 + mw;
        first_pend = 1'b1;
    endtask

    task automatic pulse_start(input int s, input bit record);
        @(negedge clk);
        if (record) start_cyc = cyc;
        dump_start[s] = 1'b1;
        @(negedge clk);
        dump_start[s] = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (dones != 0) break;
        end
        repeat (5) @(negedge clk);
        chk("single_done", 32'(dones), 32'd1);
        chk("idle_busy", 32'(busy[sel]), 32'd0);
        chk("word_queue_empty", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic chk_idle(input int s);
        chk("rst_tx_word", tx_word[s], 32'd0);
        chk("rst_mem_addr", mem_addr[s], 32'd0);
        chk("rst_ctl", 32'({reg_addr[s], mem_rd[s], tx_start[s], busy[s], dump_done[s]}), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        repeat (3) @(negedge clk);
        for (int s = 0; s < 3; s++) chk_idle(s);
        rst_n = 1'b1;

        // Four memory words.
        setup(0, 4, 32'h0);
        pulse_start(0, 1'b1);
        wait_done(1500);

        // No memory section.
        setup(1, 0, 32'h0);
        pulse_start(1, 1'b1);
        wait_done(1500);

        // Base near the top of the address space wraps.
        setup(2, 3, 32'hFFFF_FFF8);
        pulse_start(2, 1'b1);
        wait_done(1500);

        // Restart requests while busy plus stray tx_done in RD and SEND.
        spur_mode = 1'b1;
        setup(0, 4, 32'h0);
        pulse_start(0, 1'b1);
        repeat (30) @(negedge clk);
        pulse_start(0, 1'b0);
        repeat (200) @(negedge clk);
        pulse_start(0, 1'b0);
        wait_done(1500);
        spur_mode = 1'b0;

        // Async reset while waiting on register word 7.
        setup(0, 4, 32'h0);
        pulse_start(0, 1'b1);
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            if (words >= 10) break;
        end
        repeat (3) @(negedge clk);
        chk("reach_reg7", 32'(words), 32'd10);
        #2;
        rst_n = 1'b0;
        #1;
        chk_idle(0);
        repeat (3) @(negedge clk);
        chk_idle(0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("no_resume", 32'(busy[0]), 32'd0);
        setup(0, 4, 32'h0);
        pulse_start(0, 1'b1);
        wait_done(1500);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
